tennis_match_scorer: RTL and testbench

Downstream of the ball-movement stage: consumes its per-rally point strobes and keeps full tennis scoring. Scoring runs through points (0/15/30/40/deuce/advantage), games, sets and match. Drives BCD point digits, game/set counts, server indication and match-over status to the seven-segment display stage. All logic runs in the game tick domain.

---
 rtl/tennis_match_scorer.sv | 220 ++++++++++++++++++++++
 tb/tb_tennis_match_scorer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tennis_match_scorer.sv
// Tennis scoring: points, games, sets and match for two players.
// Optional tiebreak at GAMES_PER_SET-all is enabled by defining TIEBREAK_EN.
module tennis_match_scorer #(
    parameter int GAMES_PER_SET = 6,
    parameter int SETS_TO_WIN   = 2
) (
    input  logic       new_clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic [7:0] disp_p1,
    output logic [7:0] disp_p2,
    output logic [3:0] games_p1,
    output logic [3:0] games_p2,
    output logic [1:0] sets_p1,
    output logic [1:0] sets_p2,
    output logic       server,
    output logic       deuce,
    output logic       tiebreak,
    output logic       game_won,
    output logic       set_won,
    output logic       match_over,
    output logic       winner
);
    localparam logic [3:0] GPS = GAMES_PER_SET[3:0];
    localparam logic [1:0] STW = SETS_TO_WIN[1:0];

    typedef enum logic [2:0] {NORMAL, DEUCE, ADV_P1, ADV_P2, TB} state_t;

    state_t      state_q, state_d;
    logic [3:0]  p1_q, p1_d, p2_q, p2_d;
    logic [3:0]  g1_q, g1_d, g2_q, g2_d;
    logic [1:0]  s1_q, s1_d, s2_q, s2_d;
    logic        srv_q, srv_d, tb_srv_q, tb_srv_d;
    logic        tb_clr_q, tb_clr_d;
    logic        gw_q, gw_d, sw_q, sw_d;
    logic        mo_q, mo_d, win_q, win_d;
    logic        dc_q, dc_d, tb_q, tb_d;
    logic [7:0]  d1_q, d1_d, d2_q, d2_d;
    logic        who, game_end, set_end;
    logic [3:0]  g_win, g_lose;

    function automatic logic tb_win(logic [3:0] a, logic [3:0] b);
        return (a == 4'd15) ||
               (a >= 4'd7 && {1'b0, a} >= {1'b0, b} + 5'd2);
    endfunction

    function automatic logic [7:0] pt_disp(logic [3:0] idx);
        unique case (idx)
            4'd0:    return 8'h00;
            4'd1:    return 8'h15;
            4'd2:    return 8'h30;
            default: return 8'h40;
        endcase
    endfunction

    function automatic logic [7:0] bcd(logic [3:0] v);
        return (v >= 4'd10) ? {4'd1, v - 4'd10} : {4'd0, v};
    endfunction

    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        g1_d     = tb_clr_q ? 4'd0 : g1_q;
        g2_d     = tb_clr_q ? 4'd0 : g2_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        srv_d    = srv_q;
        tb_srv_d = tb_srv_q;
        tb_clr_d = 1'b0;
        gw_d     = 1'b0;
        sw_d     = 1'b0;
        mo_d     = mo_q;
        win_d    = win_q;
        who      = point_p2;
        game_end = 1'b0;
        set_end  = 1'b0;
        g_win    = 4'd0;
        g_lose   = 4'd0;
        if ((point_p1 ^ point_p2) && !mo_q) begin
            unique case (state_q)
                NORMAL: begin
                    if ((!who && p1_q == 4'd3) || (who && p2_q == 4'd3)) begin
                        game_end = 1'b1;
                    end else begin
                        if (who) p2_d = p2_q + 4'd1;
                        else     p1_d = p1_q + 4'd1;
                        if (p1_d == 4'd3 && p2_d == 4'd3) state_d = DEUCE;
                    end
                end
                DEUCE:  state_d = who ? ADV_P2 : ADV_P1;
                ADV_P1: if (!who) game_end = 1'b1; else state_d = DEUCE;
                ADV_P2: if (who)  game_end = 1'b1; else state_d = DEUCE;
                TB: begin
                    if (who) p2_d = p2_q + 4'd1;
                    else     p1_d = p1_q + 4'd1;
                    if (tb_win(p1_d, p2_d) || tb_win(p2_d, p1_d)) begin
                        game_end = 1'b1;
                    end else if (p1_d[0] ^ p2_d[0]) begin
                        // serve changes after odd point totals: 1, 3, 5, ...
                        srv_d = ~srv_q;
                    end
                end
                default: state_d = NORMAL;
            endcase
        end
        if (game_end) begin
            state_d = NORMAL;
            p1_d    = 4'd0;
            p2_d    = 4'd0;
            gw_d    = 1'b1;
            if (who) g2_d = g2_d + 4'd1;
            else     g1_d = g1_d + 4'd1;
            g_win  = who ? g2_d : g1_d;
            g_lose = who ? g1_d : g2_d;
            if (state_q == TB) begin
                srv_d   = ~tb_srv_q;
                set_end = 1'b1;
            end else begin
                srv_d   = ~srv_q;
                set_end = g_win >= GPS &&
                          {1'b0, g_win} >= {1'b0, g_lose} + 5'd2;
`ifdef TIEBREAK_EN
                if (!set_end && g1_d == GPS && g2_d == GPS) begin
                    state_d  = TB;
                    tb_srv_d = srv_d;
                end
`else
                if (g_win == 4'd15) set_end = 1'b1;
`endif
            end
            if (set_end) begin
                sw_d = 1'b1;
                if (who) s2_d = s2_q + 2'd1;
                else     s1_d = s1_q + 2'd1;
                // a tiebreak set shows its final game score for one tick
                if (state_q == TB) begin
                    tb_clr_d = 1'b1;
                end else begin
                    g1_d = 4'd0;
                    g2_d = 4'd0;
                end
                if ((who ? s2_d : s1_d) == STW) begin
                    mo_d     = 1'b1;
                    win_d    = who;
                    tb_clr_d = 1'b0;
                end
            end
        end
        dc_d = (state_d == DEUCE);
        tb_d = (state_d == TB);
        d1_d = pt_disp(p1_d);
        d2_d = pt_disp(p2_d);
        unique case (state_d)
            DEUCE:  begin d1_d = 8'h40; d2_d = 8'h40; end
            ADV_P1: begin d1_d = 8'hAD; d2_d = 8'h40; end
            ADV_P2: begin d1_d = 8'h40; d2_d = 8'hAD; end
            TB:     begin d1_d = bcd(p1_d); d2_d = bcd(p2_d); end
            default: ;
        endcase
    end

    always_ff @(posedge new_clk) begin
        if (reset || clear) begin
            state_q  <= NORMAL;
            p1_q     <= 4'd0;
            p2_q     <= 4'd0;
            g1_q     <= 4'd0;
            g2_q     <= 4'd0;
            s1_q     <= 2'd0;
            s2_q     <= 2'd0;
            srv_q    <= 1'b0;
            tb_srv_q <= 1'b0;
            tb_clr_q <= 1'b0;
            gw_q     <= 1'b0;
            sw_q     <= 1'b0;
            mo_q     <= 1'b0;
            win_q    <= 1'b0;
            dc_q     <= 1'b0;
            tb_q     <= 1'b0;
            d1_q     <= 8'h00;
            d2_q     <= 8'h00;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            g1_q     <= g1_d;
            g2_q     <= g2_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            srv_q    <= srv_d;
            tb_srv_q <= tb_srv_d;
            tb_clr_q <= tb_clr_d;
            gw_q     <= gw_d;
            sw_q     <= sw_d;
            mo_q     <= mo_d;
            win_q    <= win_d;
            dc_q     <= dc_d;
            tb_q     <= tb_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
        end
    end

    assign disp_p1    = d1_q;
    assign disp_p2    = d2_q;
    assign games_p1   = g1_q;
    assign games_p2   = g2_q;
    assign sets_p1    = s1_q;
    assign sets_p2    = s2_q;
    assign server     = srv_q;
    assign deuce      = dc_q;
    assign tiebreak   = tb_q;
    assign game_won   = gw_q;
    assign set_won    = sw_q;
    assign match_over = mo_q;
    assign winner     = win_q;
endmodule

// File: tb/tb_tennis_match_scorer.sv
// Bench for tennis_match_scorer: directed and random rallies
// checked each tick against a point-count reference model.
module tb_tennis_match_scorer;
    localparam int GPS = 6;
    localparam int STW = 2;
`ifdef TIEBREAK_EN
    localparam bit TBEN = 1'b1;
`else
    localparam bit TBEN = 1'b0;
`endif

    logic       new_clk = 1'b0;
    logic       reset = 1'b1, clear = 1'b0;
    logic       point_p1 = 1'b0, point_p2 = 1'b0;
    logic [7:0] disp_p1, disp_p2;
    logic [3:0] games_p1, games_p2;
    logic [1:0] sets_p1, sets_p2;
    logic       server, deuce, tiebreak, game_won, set_won;
    logic       match_over, winner;

    int n_cmp = 0;
    int n_bad = 0;

    // model: raw rally counts per player, games, sets and flags
    int mp[2], mg[2], ms[2];
    bit mtb, msrv, mfirst, mover, mwin, mgw, msw, mpend;

    tennis_match_scorer #(.GAMES_PER_SET(GPS), .SETS_TO_WIN(STW)) dut (
        .new_clk(new_clk), .reset(reset), .clear(clear),
        .point_p1(point_p1), .point_p2(point_p2),
        .disp_p1(disp_p1), .disp_p2(disp_p2),
        .games_p1(games_p1), .games_p2(games_p2),
        .sets_p1(sets_p1), .sets_p2(sets_p2),
        .server(server), .deuce(deuce), .tiebreak(tiebreak),
        .game_won(game_won), .set_won(set_won),
        .match_over(match_over), .winner(winner)
    );

    always #5 new_clk = ~new_clk;

    task automatic chk(string tag, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_disp(int me, int op);
        if (mtb) return (me / 10) * 16 + (me % 10);
        if (me >= 3 && op >= 3) return (me > op) ? 'hAD : 'h40;
        case (me)
            0:       return 'h00;
            1:       return 'h15;
            2:       return 'h30;
            default: return 'h40;
        endcase
    endfunction

    task automatic m_reset();
        mp = '{0, 0}; mg = '{0, 0}; ms = '{0, 0};
        mtb = 0; msrv = 0; mfirst = 0; mover = 0;
        mwin = 0; mgw = 0; msw = 0; mpend = 0;
    endtask

    task automatic m_step(bit a1, bit a2, bit clr);
        int w, l, n;
        mgw = 0;
        msw = 0;
        if (clr) begin
            m_reset();
            return;
        end
        if (mpend) begin
            mg = '{0, 0};
            mpend = 0;
        end
        if ((a1 ^ a2) && !mover) begin
            w = a2 ? 1 : 0;
            l = 1 - w;
            mp[w]++;
            if (mtb) begin
                n = mp[0] + mp[1];
                if ((mp[w] >= 7 && mp[w] - mp[l] >= 2) || mp[w] == 15) begin
                    mgw = 1; msw = 1;
                    mg[w]++; ms[w]++;
                    mp = '{0, 0};
                    mtb = 0;
                    msrv = !mfirst;
                    if (ms[w] == STW) begin mover = 1; mwin = bit'(w); end
                    else mpend = 1;
                end else begin
                    msrv = mfirst ^ bit'(((n + 1) / 2) % 2);
                end
            end else if (mp[w] >= 4 && mp[w] - mp[l] >= 2) begin
                mgw = 1;
                mp = '{0, 0};
                msrv = !msrv;
                mg[w]++;
                if ((mg[w] >= GPS && mg[w] - mg[l] >= 2) ||
                    (!TBEN && mg[w] == 15)) begin
                    msw = 1;
                    ms[w]++;
                    mg = '{0, 0};
                    if (ms[w] == STW) begin mover = 1; mwin = bit'(w); end
                end else if (TBEN && mg[0] == GPS && mg[1] == GPS) begin
                    mtb = 1;
                    mfirst = msrv;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("disp_p1", int'(disp_p1), m_disp(mp[0], mp[1]));
        chk("disp_p2", int'(disp_p2), m_disp(mp[1], mp[0]));
        chk("games_p1", int'(games_p1), mg[0]);
        chk("games_p2", int'(games_p2), mg[1]);
        chk("sets_p1", int'(sets_p1), ms[0]);
        chk("sets_p2", int'(sets_p2), ms[1]);
        chk("server", int'(server), int'(msrv));
        chk("deuce", int'(deuce),
            int'(!mtb && mp[0] >= 3 && mp[0] == mp[1]));
        chk("tiebreak", int'(tiebreak), int'(mtb));
        chk("game_won", int'(game_won), int'(mgw));
        chk("set_won", int'(set_won), int'(msw));
        chk("match_over", int'(match_over), int'(mover));
        chk("winner", int'(winner), int'(mwin));
    endtask

    task automatic tick(bit a1, bit a2, bit rst, bit clr);
        point_p1 = a1;
        point_p2 = a2;
        reset = rst;
        clear = clr;
        @(posedge new_clk);
        #1;
        m_step(a1, a2, rst | clr);
        check_all();
        point_p1 = 0;
        point_p2 = 0;
        reset = 0;
        clear = 0;
    endtask

    task automatic pts(bit who, int n);
        repeat (n) tick(!who, who, 0, 0);
    endtask

    task automatic to_six_all();
        for (int i = 0; i < 2 * GPS; i++) pts(bit'(i % 2), 4);
    endtask

    initial begin
        int bias;
        m_reset();
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        pts(0, 4);
        tick(0, 0, 0, 0);

        tick(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            pts(0, 1);
            pts(1, 1);
        end
        pts(0, 1);
        pts(1, 1);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        pts(1, 2);

        tick(0, 0, 1, 0);
        pts(0, 4 * 2 * GPS);
        pts(1, 1);
        tick(1, 1, 0, 0);

        tick(0, 0, 1, 0);
        to_six_all();
        pts(0, 6);
        pts(1, 6);
        pts(0, 2);
        pts(1, 5);

        tick(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) pts(bit'(i % 2), 4);
        pts(1, 3);
        pts(0, 3);
        pts(1, 1);
        tick(1, 0, 0, 1);
        tick(0, 0, 0, 0);

        tick(0, 0, 1, 0);
        to_six_all();
        pts(0, 3);
        tick(0, 1, 1, 0);

        tick(0, 0, 1, 0);
        for (int i = 0; i < 8000; i++) begin
            int r;
            bias = ((i / 500) % 2 == 1) ? 30 : 70;
            r = $urandom_range(99);
            if ($urandom_range(999) == 0) begin
                tick(bit'($urandom_range(1)), bit'($urandom_range(1)), 0, 1);
            end else if (mover && $urandom_range(9) == 0) begin
                tick(0, 0, bit'($urandom_range(1)), 1);
            end else if (r < 4) begin
                tick(1, 1, 0, 0);
            end else if (r < 12) begin
                tick(0, 0, 0, 0);
            end else if ($urandom_range(99) < bias) begin
                tick(1, 0, 0, 0);
            end else begin
                tick(0, 1, 0, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
